// File: rtl/multi_edge_detect.sv
// ---------------------------------------------------------------------------
// multi_edge_detect
//   Multi-channel edge detector for board-level inputs (keys, external
//   strobes). Each channel runs: async pin -> SYNC_STAGES-flop synchroniser
//   -> optional debounce filter -> registered one-cycle h2l/l2h pulses and
//   sticky event flags with a per-channel clear.
//
// Build option:
//   DEBOUNCE_EN  defined   : a level change is accepted only after the
//                            synchronised input has differed from the
//                            filtered level for DEB_CYCLES consecutive cycles.
//                undefined : no filter; the filtered level follows the
//                            synchronised input every cycle, and DEB_CYCLES
//                            is ignored.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   synchronous, active-high reset
//   pin_in     in   CH  asynchronous raw inputs
//   evt_clr    in   CH  per-channel clear of both sticky flags
//   level_out  out  CH  filtered, synchronised level
//   h2l_sig    out  CH  one-cycle pulse on filtered 1->0
//   l2h_sig    out  CH  one-cycle pulse on filtered 0->1
//   h2l_evt    out  CH  sticky: h2l seen since the last clear
//   l2h_evt    out  CH  sticky: l2h seen since the last clear
//   evt_any    out  1   OR of every sticky flag bit
// ---------------------------------------------------------------------------
module multi_edge_detect #(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 16,
  parameter logic RST_LEVEL   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] pin_in,
  input  logic [CH-1:0] evt_clr,
  output logic [CH-1:0] level_out,
  output logic [CH-1:0] h2l_sig,
  output logic [CH-1:0] l2h_sig,
  output logic [CH-1:0] h2l_evt,
  output logic [CH-1:0] l2h_evt,
  output logic          evt_any
);

  // Elaboration-time guards on the parameter ranges this structure supports.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("multi_edge_detect: SYNC_STAGES must be >= 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("multi_edge_detect: DEB_CYCLES must be >= 1");
  end

  // -------------------------------------------------------------------------
  // Synchroniser
  // -------------------------------------------------------------------------
  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] raw;

  // NOTE: the chain is reset like any other register: RST_LEVEL is the idle
  // pin level, and loading it stops a spurious edge from appearing while the
  // flops fill after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {CH{RST_LEVEL}};
    end else begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's old value, so the chain really shifts by one per edge.
      sync_q[0] <= pin_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Filtered level
  // -------------------------------------------------------------------------
  logic [CH-1:0] level_q, level_d;

`ifdef DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TERM = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];

  // The counter tracks how long raw has disagreed with the filtered level.
  // Any cycle of agreement restarts it, so a glitch shorter than DEB_CYCLES
  // never reaches level_out.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred.
    level_d = level_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (raw[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        level_d[i] = raw[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  always_comb begin
    level_d = raw;
  end
`endif

  // -------------------------------------------------------------------------
  // Pulses and sticky flags
  // -------------------------------------------------------------------------
  logic [CH-1:0] h2l_q, h2l_d;
  logic [CH-1:0] l2h_q, l2h_d;
  logic [CH-1:0] h2l_evt_q, h2l_evt_d;
  logic [CH-1:0] l2h_evt_q, l2h_evt_d;
  logic          evt_any_q, evt_any_d;

  always_comb begin
    // Pulses are derived from the level transition itself, so they land in
    // the same edge that updates level_out and can never both fire.
    h2l_d     = level_q & ~level_d;
    l2h_d     = ~level_q & level_d;
    // Set is OR-ed in after the clear, so a simultaneous set wins.
    h2l_evt_d = (h2l_evt_q & ~evt_clr) | h2l_d;
    l2h_evt_d = (l2h_evt_q & ~evt_clr) | l2h_d;
    evt_any_d = |(h2l_evt_d | l2h_evt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= {CH{RST_LEVEL}};
      h2l_q     <= '0;
      l2h_q     <= '0;
      h2l_evt_q <= '0;
      l2h_evt_q <= '0;
      evt_any_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      h2l_q     <= h2l_d;
      l2h_q     <= l2h_d;
      h2l_evt_q <= h2l_evt_d;
      l2h_evt_q <= l2h_evt_d;
      evt_any_q <= evt_any_d;
    end
  end

  assign level_out = level_q;
  assign h2l_sig   = h2l_q;
  assign l2h_sig   = l2h_q;
  assign h2l_evt   = h2l_evt_q;
  assign l2h_evt   = l2h_evt_q;
  assign evt_any   = evt_any_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// ---------------------------------------------------------------------------
// tb_multi_edge_detect
//   Self-checking bench for multi_edge_detect (CH=4, SYNC_STAGES=2,
//   DEB_CYCLES=4, RST_LEVEL=1). A window-based reference model predicts every
//   output each cycle; directed sequences cover reset, latency, glitch
//   rejection, set-wins-over-clear and mid-debounce reset, followed by
//   randomized pins, clears and occasional resets. Works with DEBOUNCE_EN
//   either defined or undefined.
// ---------------------------------------------------------------------------
module tb_multi_edge_detect;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT  = SYNC + DEB - 1;
`else
  localparam int LAT  = SYNC;
`endif
  localparam int WAIT_MAX = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] pin_in;
  logic [CH-1:0] evt_clr;
  logic [CH-1:0] level_out, h2l_sig, l2h_sig, h2l_evt, l2h_evt;
  logic          evt_any;

  multi_edge_detect #(
    .CH(CH), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .RST_LEVEL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .evt_clr(evt_clr),
    .level_out(level_out), .h2l_sig(h2l_sig), .l2h_sig(l2h_sig),
    .h2l_evt(h2l_evt), .l2h_evt(l2h_evt), .evt_any(evt_any)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: pin samples are delayed SYNC edges; with debounce the
  // level flips when the last DEB raw samples all oppose the current level
  // and none of them predates the previous level change (or reset).
  // -------------------------------------------------------------------------
  logic [CH-1:0] sq[$];
  logic [CH-1:0] rawq[$];
  int            age [CH];
  logic [CH-1:0] m_lvl, m_h2l, m_l2h, m_hev, m_lev;
  logic          m_any;
  bit            model_ok = 1'b0;

  task automatic model_step();
    logic [CH-1:0] raw, nl;
    bit            all_opp;
    if (rst) begin
      sq.delete();
      for (int k = 0; k < SYNC; k++) sq.push_back({CH{1'b1}});
      rawq.delete();
      for (int i = 0; i < CH; i++) age[i] = 0;
      m_lvl = '1; m_h2l = '0; m_l2h = '0; m_hev = '0; m_lev = '0; m_any = 1'b0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    raw = sq.pop_front();
    sq.push_back(pin_in);
`ifdef DEBOUNCE_EN
    rawq.push_back(raw);
    if (rawq.size() > DEB) void'(rawq.pop_front());
    nl = m_lvl;
    for (int i = 0; i < CH; i++) begin
      age[i]++;
      if (rawq.size() == DEB && age[i] >= DEB) begin
        all_opp = 1'b1;
        foreach (rawq[j]) if (rawq[j][i] == m_lvl[i]) all_opp = 1'b0;
        if (all_opp) begin
          nl[i]  = ~m_lvl[i];
          age[i] = 0;
        end
      end
    end
`else
    all_opp = 1'b0;
    nl = raw;
`endif
    m_h2l = m_lvl & ~nl;
    m_l2h = ~m_lvl & nl;
    m_lvl = nl;
    m_hev = (m_hev & ~evt_clr) | m_h2l;
    m_lev = (m_lev & ~evt_clr) | m_l2h;
    m_any = |(m_hev | m_lev);
  endtask

  always @(posedge clk) model_step();

  // One cycle: wait for the falling edge, compare every output to the model.
  task automatic tick();
    @(negedge clk);
    if (model_ok) begin
      check("level_out", 32'(level_out), 32'(m_lvl));
      check("h2l_sig",   32'(h2l_sig),   32'(m_h2l));
      check("l2h_sig",   32'(l2h_sig),   32'(m_l2h));
      check("h2l_evt",   32'(h2l_evt),   32'(m_hev));
      check("l2h_evt",   32'(l2h_evt),   32'(m_lev));
      check("evt_any",   32'(evt_any),   32'(m_any));
    end
  endtask

  // Cycles from now until h2l_sig[ch] is seen high, bounded by WAIT_MAX.
  task automatic wait_h2l(input int ch, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!h2l_sig[ch] && n <= WAIT_MAX);
  endtask

  int n;

  initial begin
    rst = 1'b1; pin_in = 4'hF; evt_clr = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset: level high, nothing fires.
    repeat (12) tick();
    check("idle_level", 32'(level_out), 32'h0000000F);
    check("idle_any",   32'(evt_any),   32'h0);

    // Falling edge on ch0: pulse lands LAT edges after first sample.
    pin_in[0] = 1'b0;
    wait_h2l(0, n);
    check("ch0_h2l_latency", 32'(n), 32'(LAT + 1));
    tick();
    check("ch0_h2l_evt",  32'(h2l_evt), 32'h1);
    check("ch0_any",      32'(evt_any), 32'h1);
    check("ch0_level",    32'(level_out), 32'hE);
    repeat (8) tick();

    // Short low pulse on ch1 (3 cycles < DEB).
    pin_in[1] = 1'b0;
    repeat (3) tick();
    pin_in[1] = 1'b1;
    repeat (10) tick();
`ifdef DEBOUNCE_EN
    check("ch1_glitch_level", 32'(level_out[1]), 32'h1);
    check("ch1_glitch_flags", 32'({h2l_evt[1], l2h_evt[1]}), 32'h0);
`endif

    // Rising edge on ch0 with evt_clr[0] in the same cycle: set wins.
    pin_in[0] = 1'b1;
    repeat (LAT) tick();
    evt_clr[0] = 1'b1;
    tick();
    evt_clr[0] = 1'b0;
    check("setwins_l2h_evt0", 32'(l2h_evt[0]), 32'h1);
    check("setwins_h2l_evt0", 32'(h2l_evt[0]), 32'h0);
    check("setwins_l2h_sig0", 32'(l2h_sig[0]), 32'h1);
    evt_clr = 4'hF;
    tick();
    evt_clr = '0;
    repeat (4) tick();

    // Reset in the middle of a ch2 debounce, then full latency after release.
    pin_in[2] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_level", 32'(level_out), 32'hF);
    check("midrst_pulse", 32'({h2l_sig, l2h_sig}), 32'h0);
    rst = 1'b0;
    wait_h2l(2, n);
    check("ch2_post_rst_latency", 32'(n), 32'(LAT + 1));
    repeat (6) tick();

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(7) == 0) pin_in[i] = ~pin_in[i];
      for (int i = 0; i < CH; i++)
        evt_clr[i] = ($urandom_range(5) == 0);
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0; evt_clr = '0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
